// File: rtl/mem_arbiter.sv
// Arbiter that shares one fixed-latency single-port memory between the I-side and D-side requesters.
// It latches the winning request, drives the memory for LAT cycles, then pulses that side's valid for one cycle.
module mem_arbiter #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_data,
  output logic        i_valid,
  output logic        i_stall,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        side_q, side_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        last_q, last_d;
  logic [15:0] i_data_q, i_data_d;
  logic [15:0] d_rdata_q, d_rdata_d;

  logic cand_i, cand_d, grant_d;

  // In DONE the side just served still shows its old request, so it sits out this round.
  assign cand_i  = i_req & ~((state_q == DONE) & ~side_q);
  assign cand_d  = d_req & ~((state_q == DONE) & side_q);
  assign grant_d = cand_d & (~cand_i | ~last_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    side_d    = side_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    last_d    = last_q;
    i_data_d  = i_data_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE, DONE: begin
        if (cand_i | cand_d) begin
          state_d = BUSY;
          cnt_d   = 4'(LAT - 1);
          side_d  = grant_d;
          last_d  = grant_d;
          wr_d    = grant_d & d_wr;
          addr_d  = grant_d ? d_addr : i_addr;
          if (grant_d) begin
            wdata_d = d_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          if (!wr_q) begin
            if (side_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              i_data_d = mem_rdata;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      side_q    <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= 16'd0;
      wdata_q   <= 16'd0;
      last_q    <= 1'b0;
      i_data_q  <= 16'd0;
      d_rdata_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      side_q    <= side_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      last_q    <= last_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_en    = (state_q == BUSY);
  assign mem_wr    = wr_q & mem_en;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_valid   = (state_q == DONE) & ~side_q;
  assign d_valid   = (state_q == DONE) & side_q;
  assign i_data    = i_data_q;
  assign d_rdata   = d_rdata_q;
  assign i_stall   = i_req & ~i_valid;
  assign d_stall   = d_req & ~d_valid;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port, fixed-latency unified memory between the instruction-fetch requester (I-side) and the load/store requester (D-side) of the 5-stage pipeline. The arbiter latches each granted request and drives the memory for `LAT` cycles, then returns read data with a one-cycle valid pulse. It produces per-side stall signals that the pipeline uses to freeze the PC, IF/ID and later stages. On contention it alternates grants, with the D-side winning the first tie after reset.

## Interface
- `LAT`, default 4: memory access latency in cycles; legal range 1..15.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `i_req`  in  1: I-side read request (level); hold with `i_addr` stable until `i_valid`.
- `i_addr`  in  16: I-side address.
- `i_data`  out  16: I-side read data; valid while `i_valid`=1, held otherwise.
- `i_valid`  out  1: one-cycle pulse; I-side transaction complete.
- `i_stall`  out  1: `i_req & ~i_valid` (combinational).
- `d_req`  in  1: D-side request (level); hold with `d_wr`, `d_addr` and `d_wdata` stable until `d_valid`.
- `d_wr`  in  1: 1 = write, 0 = read.
- `d_addr`  in  16: D-side address.
- `d_wdata`  in  16: D-side write data.
- `d_rdata`  out  16: D-side read data; updated only by reads; held otherwise.
- `d_valid`  out  1: one-cycle pulse; D-side transaction complete (reads and writes).
- `d_stall`  out  1: `d_req & ~d_valid` (combinational).
- `mem_en`  out  1: memory enable; 1 for exactly `LAT` cycles per transaction.
- `mem_wr`  out  1: latched write flag; 0 whenever `mem_en`=0.
- `mem_addr`  out  16: latched address.
- `mem_wdata`  out  16: latched write data.
- `mem_rdata`  in  16: memory read data; must be valid in the last BUSY cycle.

## Operation
- FSM states:
  - IDLE: no transaction in progress.
  - BUSY: `mem_en`=1; 4-bit down-counter `cnt` runs from `LAT-1` to 0.
  - DONE: one cycle; the served side's valid output is 1.
- Arbitration runs in IDLE and DONE. The candidate set is the requests that are high. In DONE, the side just served is excluded, because its request still shows the old address.
  - One candidate: grant it.
  - Both candidates: grant the side not granted last. The `last` register resets to I, so D wins the first tie.
- On a grant:
  - Latch the side, `wr` (0 for I), address and wdata.
  - Update `last`.
  - Set `cnt`=`LAT-1` and enter BUSY.
- DONE with no grant: go to IDLE.
- BUSY with `cnt`≠0: decrement `cnt`.
- BUSY with `cnt`=0, entering DONE:
  - I-side read: capture `mem_rdata` into `i_data`.
  - D-side read: capture `mem_rdata` into `d_rdata`.
  - D-side write: capture nothing.
- `mem_wr`, `mem_addr` and `mem_wdata` come from the latched registers. `mem_wr` is gated by `mem_en`. The address and data registers hold their values outside BUSY.
- Requester inputs are don't-care after the grant.
- Reset at any time, including mid-BUSY, aborts the transaction without completion. Outputs after reset:
  - state IDLE, `cnt`=0
  - `mem_en`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0
  - `i_valid`=0, `d_valid`=0
  - `i_data`=0, `d_rdata`=0
  - `last`=I

## Timing
- Latency: a request sampled in IDLE at cycle 0 gives BUSY in cycles 1..`LAT` and DONE (valid=1) in cycle `LAT+1`.
- Single-side streaming: the period is `LAT+2` cycles (IDLE, BUSY×`LAT`, DONE). The requester presents its next address in the cycle after valid, and that cycle is IDLE.
- Both sides requesting: the other side is granted in DONE, so its BUSY starts the next cycle. Steady alternation has a period of `LAT+1` cycles per transaction.
- `LAT`=1: BUSY lasts exactly one cycle, with `cnt`=0 on entry.
- Stall is combinational. It is high from the request cycle through the last BUSY cycle and low in the DONE cycle.
- The I-side and D-side valid outputs are never 1 in the same cycle.
- `mem_en` is 0 in IDLE and DONE, so there is no back-to-back enable without a DONE gap.

## Test plan
- Reset, `LAT`=4: all outputs 0. Assert `rst` in cycle 3 of a D-side read: `mem_en` drops immediately, no `d_valid`, and an `i_req` after release is granted normally.
- I-side read, `i_addr`=0x0010, memory returns 0xA5A5: `mem_en`=1 in cycles 1–4 with `mem_addr`=0x0010 and `mem_wr`=0. `i_valid`=1 in cycle 5 with `i_data`=0xA5A5. `i_stall`=1 in cycles 0–4.
- D-side write, `d_addr`=0x0100, `d_wdata`=0x1234: `mem_wr`=1 with that address and data for 4 cycles. `d_valid` pulses in cycle 5. `d_rdata` is unchanged.
- `i_req` and `d_req` rise in the same cycle after reset:
  - D is granted first, `d_valid` in cycle 5.
  - I is granted in cycle 5, BUSY in 6–9, `i_valid` in cycle 10.
  - With both held, grants alternate D, I, D, I.
- Single-side streaming: hold `i_req`, change `i_addr` the cycle after each `i_valid`. `i_valid` pulses every 6 cycles and each `mem_addr` matches the new address.
- `LAT`=1, D-side read of 0x0002 returning 0xBEEF: BUSY is only cycle 1, `d_valid` is in cycle 2 with `d_rdata`=0xBEEF.
